inst_fetcher: RTL and testbench
===============================

# inst_fetcher

Instruction-fetch stage directly downstream of the PC register in the IF unit. It samples the current PC, reads the 32-bit instruction from the byte-wide memory controller (or an optional direct-mapped I-cache), and presents `{inst, inst_pc}` to decode through a valid/ready handshake. After each consumed instruction it pulses `pc_update` to advance the PC register. A `flush` input aborts any fetch in flight on branch redirect.

## Interface
- `ADDR_LEN`, 32, address and instruction width
- `ICACHE_IDX_W`, 5, I-cache index bits (2^5 = 32 one-word lines); used only with `ICACHE_EN`

- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `pc_in`  in  ADDR_LEN  current PC from the PC register
- `pc_update`  out  1  one-cycle pulse that advances the PC register
- `flush`  in  1  abort the current fetch; return to IDLE
- `mem_req`  out  1  byte-read request
- `mem_addr`  out  ADDR_LEN  byte address of the request
- `mem_gnt`  in  1  request accepted this cycle
- `mem_rdata`  in  8  read byte, valid exactly 1 cycle after the grant
- `inst_valid`  out  1  instruction available to decode
- `inst`  out  ADDR_LEN  instruction word, little-endian
- `inst_pc`  out  ADDR_LEN  PC of `inst`
- `inst_ready`  in  1  decode accepts `inst` this cycle

## Operation
- States: IDLE, FETCH, OUT, ADV.
- **IDLE**
  - Latch `fetch_pc <= pc_in`.
  - With an I-cache hit on `pc_in`: load `inst` from the cache and go to OUT.
  - Otherwise clear `issue_cnt` and `recv_cnt`, then go to FETCH.
- **FETCH**
  - `mem_req = (issue_cnt < 4)`.
  - `mem_addr = fetch_pc + issue_cnt`, 32-bit wraparound.
  - Each cycle with `mem_req && mem_gnt`: `issue_cnt++`.
  - Each cycle with a grant registered on the previous cycle: `inst[8*recv_cnt +: 8] <= mem_rdata`, then `recv_cnt++`.
  - When the 4th byte is captured: fill the cache (if enabled) and go to OUT.
- **OUT**
  - `inst_valid = 1`, with `inst` and `inst_pc = fetch_pc` held stable.
  - On `inst_valid && inst_ready`: go to ADV.
- **ADV**
  - `pc_update = 1` for exactly this one cycle, then go to IDLE.
- **flush**
  - Takes priority over every other transition in every state: go to IDLE next cycle.
  - `pc_update` is suppressed.
  - A handshake in the same cycle as `flush` does not count as a consumed instruction.
  - A byte returning after the flush arrives while the block is in IDLE and is discarded.
- **Cache behaviour (`ICACHE_EN`)**
  - `flush` does not invalidate the cache.
  - Reset clears all valid bits.

## Timing
- Reset values:
  - state IDLE
  - `pc_update` = 0, `mem_req` = 0, `inst_valid` = 0
  - `mem_addr`, `inst`, `inst_pc` = 0
  - all counters = 0
- Reset is asynchronous. Asserting it mid-operation drops every output to its reset value immediately.
- Miss latency with `mem_gnt` held at 1:
  - IDLE at T0; grants at T1–T4; bytes at T2–T5.
  - `inst_valid` rises at T6.
  - Each cycle of denied grant adds one cycle.
- Hit latency: IDLE at T0, `inst_valid` at T1. No `mem_req` is raised.
- After a handshake at Tk: `pc_update` is high at Tk+1, and `pc_in` is sampled at Tk+2.
- `inst_valid` never drops without a handshake, `flush`, or reset.

## Configuration
- `ICACHE_EN` defined:
  - Direct-mapped cache of 2^`ICACHE_IDX_W` lines.
  - Index is `pc[ICACHE_IDX_W+1:2]`; tag is `pc[ADDR_LEN-1:ICACHE_IDX_W+2]`.
  - Each line holds a valid bit and one 32-bit word.
  - Lookup is combinational on `pc_in` in IDLE.
- `ICACHE_EN` undefined:
  - No cache storage.
  - IDLE always goes to FETCH; every fetch takes the miss latency.

## Test plan
- **Reset:** `rst=0` → all outputs 0, state IDLE. `rst=1` with `pc_in=0x1188`, `mem_gnt=1`, bytes 0x13,0x05,0x00,0x00 → `mem_addr` 0x1188..0x118B; `inst=0x00000513`, `inst_pc=0x1188`; `inst_valid` rises 6 cycles after IDLE.
- **Grant stalls:** `mem_gnt` low for 2 cycles between the 2nd and 3rd grants → `inst_valid` 2 cycles later; byte order still correct.
- **Backpressure:** `inst_ready=0` for 5 cycles → `inst` and `inst_pc` unchanged, no `pc_update`. Then `inst_ready=1` → single `pc_update` pulse; next fetch at `pc_in=0x118C`.
- **Flush mid-fetch:** `flush` after 2 bytes → IDLE next cycle, stale byte ignored, no `inst_valid`, no `pc_update`. The refetch from the new `pc_in` returns the correct word.
- **I-cache hit (`ICACHE_EN`):** refetch 0x1188 after the first fill → `inst_valid` one cycle after IDLE, `mem_req` stays 0, `inst=0x00000513`. Without `ICACHE_EN` → full memory fetch.
- **Reset mid-fetch:** assert `rst` during FETCH → outputs clear asynchronously; after release, the fetch restarts from IDLE.

Source files
------------

// File: rtl/inst_fetcher.sv
// -----------------------------------------------------------------------------
// inst_fetcher
//
// Instruction-fetch stage sitting right after the PC register. It samples the
// current PC, assembles a 32-bit little-endian instruction from four byte reads
// on the memory port, and offers {inst, inst_pc} to decode. After decode takes
// the word it pulses pc_update so the PC register advances.
//
// Optional feature macro: ICACHE_EN
//   When defined, a direct-mapped one-word-per-line I-cache is looked up on
//   pc_in while idle. A hit skips the memory port entirely. Without the macro
//   every fetch goes to memory.
//
// Parameters
//   ADDR_LEN      address / instruction width (32)
//   ICACHE_IDX_W  cache index bits, only present with ICACHE_EN (5 -> 32 lines)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   pc_in        current PC from the PC register
//   pc_update    one-cycle pulse advancing the PC register
//   flush        abort current fetch, return to IDLE
//   mem_req      byte-read request
//   mem_addr     byte address of the request
//   mem_gnt      request accepted this cycle
//   mem_rdata    read byte, valid the cycle after its grant
//   inst_valid   instruction available to decode
//   inst         instruction word
//   inst_pc      PC of inst
//   inst_ready   decode accepts inst this cycle
//   dbg_state    current FSM state (0 IDLE, 1 FETCH, 2 OUT, 3 ADV)
//
// Handshake: a word transfers on a rising edge where inst_valid and inst_ready
// are both high and flush is low. Once inst_valid is raised, inst and inst_pc
// hold stable and inst_valid stays high until that transfer, a flush, or reset.
// -----------------------------------------------------------------------------
module inst_fetcher #(
    parameter int ADDR_LEN = 32
`ifdef ICACHE_EN
    ,
    parameter int ICACHE_IDX_W = 5
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] pc_in,
    output logic                pc_update,
    input  logic                flush,
    output logic                mem_req,
    output logic [ADDR_LEN-1:0] mem_addr,
    input  logic                mem_gnt,
    input  logic [7:0]          mem_rdata,
    output logic                inst_valid,
    output logic [ADDR_LEN-1:0] inst,
    output logic [ADDR_LEN-1:0] inst_pc,
    input  logic                inst_ready,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_OUT   = 2'd2,
        S_ADV   = 2'd3
    } state_t;

    state_t              state_q;
    logic [ADDR_LEN-1:0] fetch_pc_q;
    logic [ADDR_LEN-1:0] mem_addr_q;
    logic [ADDR_LEN-1:0] inst_q;
    logic [2:0]          issue_cnt_q;
    logic [2:0]          recv_cnt_q;
    logic                mem_req_q;
    logic                gnt_q;      // a grant happened last cycle -> byte on mem_rdata now
    logic                inst_valid_q;
    logic                pc_update_q;

    logic [ADDR_LEN-1:0] inst_d;     // inst_q with the arriving byte merged in
    logic                last_byte;  // fourth byte is being captured this cycle
    logic                cache_hit;
    logic [ADDR_LEN-1:0] cache_word;

    always_comb begin
        inst_d = inst_q;
        inst_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mem_rdata;
    end

    assign last_byte = (state_q == S_FETCH) && gnt_q && (recv_cnt_q == 3'd3);

`ifdef ICACHE_EN
    localparam int Lines = 1 << ICACHE_IDX_W;
    localparam int TagW  = ADDR_LEN - ICACHE_IDX_W - 2;

    logic [Lines-1:0]        line_valid_q;
    logic [TagW-1:0]         line_tag_q  [Lines];
    logic [ADDR_LEN-1:0]     line_word_q [Lines];
    logic [ICACHE_IDX_W-1:0] lookup_idx;
    logic [ICACHE_IDX_W-1:0] fill_idx;

    assign lookup_idx = pc_in[ICACHE_IDX_W+1:2];
    assign fill_idx   = fetch_pc_q[ICACHE_IDX_W+1:2];
    assign cache_hit  = line_valid_q[lookup_idx] &&
                        (line_tag_q[lookup_idx] == pc_in[ADDR_LEN-1:ICACHE_IDX_W+2]);
    assign cache_word = line_word_q[lookup_idx];

    // Only valid bits need reset; tag/data are qualified by them. A fetch
    // aborted by flush in its final cycle must not leave a line behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_valid_q <= '0;
        end else if (last_byte && !flush) begin
            line_valid_q[fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (last_byte && !flush) begin
            line_tag_q[fill_idx]  <= fetch_pc_q[ADDR_LEN-1:ICACHE_IDX_W+2];
            line_word_q[fill_idx] <= inst_d;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_word = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= '0;
            mem_addr_q   <= '0;
            inst_q       <= '0;
            issue_cnt_q  <= '0;
            recv_cnt_q   <= '0;
            mem_req_q    <= 1'b0;
            gnt_q        <= 1'b0;
            inst_valid_q <= 1'b0;
            pc_update_q  <= 1'b0;
        end else begin
            gnt_q <= mem_req_q && mem_gnt;
            if (flush) begin
                // Bytes still in flight land while in IDLE, where they are ignored.
                state_q      <= S_IDLE;
                mem_req_q    <= 1'b0;
                gnt_q        <= 1'b0;
                inst_valid_q <= 1'b0;
                pc_update_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        fetch_pc_q <= pc_in;
                        if (cache_hit) begin
                            inst_q       <= cache_word;
                            inst_valid_q <= 1'b1;
                            state_q      <= S_OUT;
                        end else begin
                            issue_cnt_q <= '0;
                            recv_cnt_q  <= '0;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= pc_in;
                            state_q     <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        if (mem_req_q && mem_gnt) begin
                            issue_cnt_q <= issue_cnt_q + 3'd1;
                            mem_addr_q  <= mem_addr_q + ADDR_LEN'(1);
                            if (issue_cnt_q == 3'd3) begin
                                mem_req_q <= 1'b0;
                            end
                        end
                        if (gnt_q) begin
                            inst_q     <= inst_d;
                            recv_cnt_q <= recv_cnt_q + 3'd1;
                        end
                        if (last_byte) begin
                            inst_valid_q <= 1'b1;
                            state_q      <= S_OUT;
                        end
                    end
                    S_OUT: begin
                        if (inst_ready) begin
                            inst_valid_q <= 1'b0;
                            pc_update_q  <= 1'b1;
                            state_q      <= S_ADV;
                        end
                    end
                    S_ADV: begin
                        pc_update_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // A flush arriving during ADV must keep the PC register from advancing,
    // so the registered pulse is gated by the live flush input.
    assign pc_update  = pc_update_q && !flush;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign inst_valid = inst_valid_q;
    assign inst       = inst_q;
    assign inst_pc    = fetch_pc_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_inst_fetcher.sv
`timescale 1ns/1ps
module tb_inst_fetcher;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
`ifdef ICACHE_EN
    localparam bit CACHE_ON = 1'b1;
`else
    localparam bit CACHE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic        pc_update;
    logic        flush;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [1:0]  dbg_state;

    always #5 clk = ~clk;

    inst_fetcher #(.ADDR_LEN(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc_in      (pc_in),
        .pc_update  (pc_update),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready),
        .dbg_state  (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- memory model ----------------
    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        case (a)
            32'h0000_1188: return 8'h13;
            32'h0000_1189: return 8'h05;
            32'h0000_118A: return 8'h00;
            32'h0000_118B: return 8'h00;
            default: ;
        endcase
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ a[7:0];
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
    endfunction

    // Reference cache: line number -> last completed fetch PC and its word.
    logic [31:0] cm_pc   [int];
    logic [31:0] cm_word [int];

    // ---------------- memory responder ----------------
    int          n_grants  = 0;
    int          n_denied  = 0;
    int          stall_at  = -1;
    int          stall_len = 0;
    int          stall_cnt = 0;
    bit          gnt_random = 1'b0;
    logic [31:0] gnt_log [$];
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;

    initial begin
        mem_gnt   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mem_rdata = pend ? mem_byte(pend_addr) : 8'($urandom);
            if (n_grants != stall_at) stall_cnt = 0;
            if (mem_req && n_grants == stall_at && stall_cnt < stall_len) begin
                mem_gnt = 1'b0;
                stall_cnt++;
            end else if (gnt_random) begin
                mem_gnt = ($urandom_range(0, 3) != 0);
            end else begin
                mem_gnt = 1'b1;
            end
            pend      = mem_req && mem_gnt;
            pend_addr = mem_addr;
            if (pend) begin
                n_grants++;
                gnt_log.push_back(mem_addr);
            end else if (mem_req) begin
                n_denied++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Starts at a negedge in IDLE with pc_in already == pc; returns at the
    // negedge where inst_valid is first seen.
    task automatic run_fetch(input logic [31:0] pc, input string name, output int lat);
        int          idx, log0, den0, exp_lat;
        bit          hit, req_seen;
        logic [31:0] exp_word;
        idx      = int'((pc >> 2) % 32);
        hit      = CACHE_ON && cm_pc.exists(idx) && ((cm_pc[idx] >> 7) == (pc >> 7));
        exp_word = hit ? cm_word[idx] : mem_word(pc);
        log0     = gnt_log.size();
        den0     = n_denied;
        req_seen = 1'b0;
        lat      = 0;
        n_checks++;
        if (dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL %s start_state: got %0d expected %0d", name, dbg_state, ST_IDLE);
        end
        while (inst_valid !== 1'b1 && lat < 200) begin
            @(negedge clk);
            lat++;
            if (mem_req === 1'b1) req_seen = 1'b1;
        end
        n_checks++;
        if (inst_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: inst_valid=%b after %0d cycles, expected 1", name, inst_valid, lat);
        end else begin
            exp_lat = hit ? 1 : 6 + (n_denied - den0);
            n_checks++;
            if (lat != exp_lat) begin
                n_fail++;
                $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
            end
            n_checks++;
            if (inst !== exp_word) begin
                n_fail++;
                $display("FAIL %s inst: got %h expected %h", name, inst, exp_word);
            end
            n_checks++;
            if (inst_pc !== pc) begin
                n_fail++;
                $display("FAIL %s inst_pc: got %h expected %h", name, inst_pc, pc);
            end
            if (hit) begin
                n_checks++;
                if (req_seen || gnt_log.size() != log0) begin
                    n_fail++;
                    $display("FAIL %s hit_mem_req: req_seen=%b grants=%0d expected 0", name, req_seen, gnt_log.size() - log0);
                end
            end else begin
                n_checks++;
                if (gnt_log.size() - log0 != 4) begin
                    n_fail++;
                    $display("FAIL %s grant_count: got %0d expected 4", name, gnt_log.size() - log0);
                end else begin
                    for (int k = 0; k < 4; k++) begin
                        n_checks++;
                        if (gnt_log[log0 + k] !== 32'(pc + 32'(k))) begin
                            n_fail++;
                            $display("FAIL %s mem_addr%0d: got %h expected %h", name, k, gnt_log[log0 + k], 32'(pc + 32'(k)));
                        end
                    end
                end
            end
            cm_pc[idx]   = pc;
            cm_word[idx] = exp_word;
        end
    endtask

    // Takes the presented word; leaves the bench at the next IDLE negedge
    // with pc_in == next_pc.
    task automatic consume(input logic [31:0] next_pc, input string name);
        inst_ready = 1'b1;
        pc_in      = next_pc;
        @(negedge clk);
        inst_ready = 1'b0;
        n_checks++;
        if (pc_update !== 1'b1) begin
            n_fail++;
            $display("FAIL %s pc_update_pulse: got %b expected 1", name, pc_update);
        end
        n_checks++;
        if (inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s valid_drop: got %b expected 0", name, inst_valid);
        end
        @(negedge clk);
        n_checks++;
        if (pc_update !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL %s after_adv: pc_update=%b state=%0d expected 0/%0d", name, pc_update, dbg_state, ST_IDLE);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int lat;
        rst = 1'b0;
        pc_in = 32'h0000_1188;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({pc_update, mem_req, inst_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 000", {pc_update, mem_req, inst_valid});
        end
        n_checks++;
        if (mem_addr !== 32'h0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: addr=%h inst=%h pc=%h expected 0", mem_addr, inst, inst_pc);
        end
        n_checks++;
        if (dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        end
        cm_pc.delete();
        cm_word.delete();
        rst = 1'b1;
        run_fetch(32'h0000_1188, "reset_fetch", lat);
        n_checks++;
        if (lat != 6 || inst !== 32'h0000_0513) begin
            n_fail++;
            $display("FAIL reset_first_word: lat=%0d inst=%h expected 6/00000513", lat, inst);
        end
    endtask

    task automatic test_grant_stall();
        int lat;
        consume(32'h0000_2000, "stall_consume");
        stall_len = 2;
        stall_at  = n_grants + 2;
        run_fetch(32'h0000_2000, "stall_fetch", lat);
        n_checks++;
        if (lat != 8) begin
            n_fail++;
            $display("FAIL stall_latency: got %0d expected 8", lat);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        consume(32'h0000_1188, "bp_consume0");
        run_fetch(32'h0000_1188, "bp_fetch", lat);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (inst_valid !== 1'b1 || pc_update !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b pc_update=%b expected 1/0", c, inst_valid, pc_update);
            end
            n_checks++;
            if (inst !== 32'h0000_0513 || inst_pc !== 32'h0000_1188) begin
                n_fail++;
                $display("FAIL bp_stable%0d: inst=%h pc=%h expected 00000513/00001188", c, inst, inst_pc);
            end
        end
        consume(32'h0000_118C, "bp_consume1");
        run_fetch(32'h0000_118C, "bp_next", lat);
    endtask

    task automatic test_flush_fetch();
        int lat;
        consume(32'h0000_3000, "flush_consume");
        repeat (4) @(negedge clk);
        n_checks++;
        if (dbg_state !== ST_FETCH || inst_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_pre: state=%0d valid=%b expected %0d/0", dbg_state, inst_valid, ST_FETCH);
        end
        flush = 1'b1;
        pc_in = 32'h0000_3010;
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (dbg_state !== ST_IDLE || inst_valid !== 1'b0 || pc_update !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: state=%0d valid=%b pcu=%b req=%b expected 0/0/0/0", dbg_state, inst_valid, pc_update, mem_req);
        end
        run_fetch(32'h0000_3010, "flush_refetch", lat);
    endtask

    task automatic test_flush_out();
        int lat;
        flush      = 1'b1;
        inst_ready = 1'b1;
        pc_in      = 32'h0000_4000;
        @(negedge clk);
        flush      = 1'b0;
        inst_ready = 1'b0;
        n_checks++;
        if (pc_update !== 1'b0 || inst_valid !== 1'b0 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL flush_out: pcu=%b valid=%b state=%0d expected 0/0/0", pc_update, inst_valid, dbg_state);
        end
        run_fetch(32'h0000_4000, "flush_out_fetch", lat);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        n_checks++;
        if (pc_update !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_adv_pre: pc_update=%b expected 1", pc_update);
        end
        flush = 1'b1;
        pc_in = 32'h0000_1188;
        #1;
        n_checks++;
        if (pc_update !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_adv_suppress: pc_update=%b expected 0", pc_update);
        end
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (dbg_state !== ST_IDLE || pc_update !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_adv_idle: state=%0d pcu=%b expected 0/0", dbg_state, pc_update);
        end
    endtask

    task automatic test_icache();
        int lat;
        run_fetch(32'h0000_1188, "icache_refetch", lat);
        n_checks++;
        if (inst !== 32'h0000_0513 || lat != (CACHE_ON ? 1 : 6)) begin
            n_fail++;
            $display("FAIL icache_word: inst=%h lat=%0d expected 00000513/%0d", inst, lat, CACHE_ON ? 1 : 6);
        end
        // 0x3000 was aborted by flush, so it must never have been cached.
        consume(32'h0000_3000, "icache_consume");
        run_fetch(32'h0000_3000, "icache_flushed_line", lat);
    endtask

    task automatic test_wrap();
        int lat;
        consume(32'hFFFF_FFFE, "wrap_consume");
        run_fetch(32'hFFFF_FFFE, "wrap_fetch", lat);
    endtask

    task automatic test_random();
        int          lat;
        logic [31:0] pool [8];
        logic [31:0] pc;
        pool[0] = 32'h0000_1188;
        pool[1] = 32'h0000_118C;
        pool[2] = 32'h0000_2000;
        pool[3] = 32'h0000_2080;
        pool[4] = 32'h0000_0100;
        pool[5] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        pool[6] = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        pool[7] = 32'hFFFF_FFFE;
        gnt_random = 1'b1;
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            n_checks++;
            if (inst_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d hold: valid=%b expected 1", i, inst_valid);
            end
            pc = pool[$urandom_range(0, 7)];
            consume(pc, $sformatf("rand%0d_consume", i));
            run_fetch(pc, $sformatf("rand%0d", i), lat);
        end
        gnt_random = 1'b0;
    endtask

    task automatic test_reset_mid_fetch();
        int lat;
        consume(32'h0000_5000, "rmid_consume");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({pc_update, mem_req, inst_valid} !== 3'b000 || dbg_state !== ST_IDLE) begin
            n_fail++;
            $display("FAIL rmid_ctrl: pcu/req/valid=%b state=%0d expected 000/0", {pc_update, mem_req, inst_valid}, dbg_state);
        end
        n_checks++;
        if (mem_addr !== 32'h0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL rmid_data: addr=%h inst=%h pc=%h expected 0", mem_addr, inst, inst_pc);
        end
        cm_pc.delete();
        cm_word.delete();
        repeat (2) @(negedge clk);
        pc_in = 32'h0000_1188;
        rst   = 1'b1;
        run_fetch(32'h0000_1188, "rmid_refetch", lat);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst        = 1'b0;
        pc_in      = '0;
        flush      = 1'b0;
        inst_ready = 1'b0;
        test_reset();
        test_grant_stall();
        test_backpressure();
        test_flush_fetch();
        test_flush_out();
        test_icache();
        test_wrap();
        test_random();
        test_reset_mid_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
